// File: rtl/game_mem_arbiter_if.sv
// Bundles the requester-side and memory-side signals of the game memory arbiter.
// The arbiter uses the slave modport; the surrounding system drives the master side.
interface game_mem_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          busy;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic                          mem_we;
  logic [DATA_WIDTH-1:0]         mem_rdata;

  modport slave (
    input  req, lock, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, lock, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/game_mem_arbiter.sv
// Round-robin arbiter sharing one single-port game memory between NUM_REQ requesters,
// with a capped lock for read-modify-write sequences and one-cycle read return.
module game_mem_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LOCK_MAX   = 4
) (
  input logic               clk,
  input logic               rstn,
  game_mem_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q;
  logic [NUM_REQ-1:0]   rvalid_q;
  logic [NUM_REQ-1:0]   gnt_c;
  logic [IW-1:0]        rr_sel, gsel;
  logic                 rr_found, gvld, cap_hit;

  assign cap_hit = (cnt_q == CW'(LOCK_MAX));

  // Search starts just after the last grantee, so the last grantee has lowest priority.
  always_comb begin : rr_search
    int            idx;
    logic [IW-1:0] idx_b;
    rr_found = 1'b0;
    rr_sel   = '0;
    idx      = 0;
    idx_b    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(ptr_q) + k) % NUM_REQ;
      idx_b = IW'(idx);
      if (!rr_found && bus.req[idx_b]) begin
        rr_found = 1'b1;
        rr_sel   = idx_b;
      end
    end
  end

  always_comb begin : grant_logic
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gvld    = 1'b0;
    gsel    = '0;
    if (state_q == LOCKED && !cap_hit) begin
      if (bus.req[owner_q]) begin
        gvld  = 1'b1;
        gsel  = owner_q;
        cnt_d = cnt_q + 1'b1;
        if (!bus.lock[owner_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else begin
      // Plain arbitration; also the forced-release path once the lock cap is reached.
      state_d = IDLE;
      cnt_d   = '0;
      if (rr_found) begin
        gvld  = 1'b1;
        gsel  = rr_sel;
        ptr_d = rr_sel;
        if (bus.lock[rr_sel]) begin
          state_d = LOCKED;
          owner_d = rr_sel;
          cnt_d   = CW'(1);
        end
      end
    end
    if (!rstn) begin
      gvld = 1'b0;
    end
  end

  always_comb begin : gnt_decode
    gnt_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_c[i] = gvld && (gsel == IW'(i));
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.mem_we    = gvld & bus.we[gsel];
  assign bus.mem_addr  = gvld ? bus.addr[gsel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.mem_wdata = gvld ? bus.wdata[gsel*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.rvalid    = rvalid_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ptr_q    <= IW'(NUM_REQ - 1);
      owner_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d == LOCKED);
      rvalid_q <= gnt_c & ~bus.we;
    end
  end
endmodule

// File: tb/tb_game_mem_arbiter.sv
// Bench for game_mem_arbiter: directed scenarios plus randomized traffic, each cycle
// compared against a behavioural model of grants, memory contents and read return.
module tb_game_mem_arbiter;
  localparam int NR = 3;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LM = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  game_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  game_mem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Environment memory: registered read, one-cycle latency.
  logic [DW-1:0] bmem [16];
  always @(posedge clk) begin
    if (bus.mem_we) bmem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= bmem[bus.mem_addr];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int            m_ptr = 0;
  int            m_owner = -1;
  int            m_cnt = 0;
  bit            m_init = 0;
  logic [NR-1:0] m_rv = '0;
  logic [DW-1:0] m_rd = '0;
  logic [DW-1:0] m_mem [16];

  logic [NR-1:0] obs_gnt, obs_rv;
  logic [DW-1:0] obs_rd;
  logic          obs_we, obs_busy;

  function automatic int pick();
    if (!rstn) return -1;
    if (m_owner >= 0 && m_cnt < LM) return bus.req[m_owner] ? m_owner : -1;
    for (int k = 1; k <= NR; k++) begin
      if (bus.req[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic tick();
    int            g;
    logic [AW-1:0] a;
    logic [NR-1:0] eg;
    @(negedge clk);
    g  = pick();
    eg = (g < 0) ? '0 : NR'(1 << g);
    obs_gnt = bus.gnt; obs_we = bus.mem_we; obs_rv = bus.rvalid;
    obs_rd = bus.rdata; obs_busy = bus.busy;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("mem_we", 32'(bus.mem_we), (g >= 0) ? 32'(bus.we[g]) : 32'd0);
    chk("mem_addr", 32'(bus.mem_addr), (g >= 0) ? 32'(bus.addr[g*AW +: AW]) : 32'd0);
    chk("mem_wdata", 32'(bus.mem_wdata), (g >= 0) ? 32'(bus.wdata[g*DW +: DW]) : 32'd0);
    if (m_init) begin
      chk("rvalid", 32'(bus.rvalid), 32'(m_rv));
      if (m_rv != 0) chk("rdata", 32'(bus.rdata), 32'(m_rd));
      chk("busy", 32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    end
    if (!rstn) begin
      m_ptr = NR - 1; m_owner = -1; m_cnt = 0; m_rv = '0; m_init = 1;
    end else begin
      m_rv = '0;
      if (g >= 0) begin
        a = bus.addr[g*AW +: AW];
        if (bus.we[g]) m_mem[a] = bus.wdata[g*DW +: DW];
        else begin
          m_rv = NR'(1 << g);
          m_rd = m_mem[a];
        end
      end
      if (m_owner >= 0 && m_cnt < LM) begin
        if (g >= 0 && bus.lock[g]) m_cnt++;
        else begin m_owner = -1; m_cnt = 0; end
      end else begin
        m_owner = -1; m_cnt = 0;
        if (g >= 0) begin
          m_ptr = g;
          if (bus.lock[g]) begin m_owner = g; m_cnt = 1; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [NR-1:0] rq, input logic [NR-1:0] lk, input logic [NR-1:0] w,
                     input logic [NR*AW-1:0] ad, input logic [NR*DW-1:0] wd);
    bus.req = rq; bus.lock = lk; bus.we = w; bus.addr = ad; bus.wdata = wd;
  endtask

  initial begin
    logic [NR-1:0] exp_seq [4];
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
    rstn = 1'b0;
    set('0, '0, '0, '0, '0);
    tick();
    rstn = 1'b1;
    // Preload every memory word through requester 0
    for (int i = 0; i < 16; i++) begin
      set(3'b001, 3'b000, 3'b001, 12'(i), 24'($urandom_range(0, 255)));
      tick();
    end
    rstn = 1'b0; set('0, '0, '0, '0, '0); tick();
    chk("rst_gnt", 32'(obs_gnt), 32'd0);
    rstn = 1'b1;

    // Round-robin rotation with all requesters reading
    for (int i = 0; i < 4; i++) begin
      set(3'b111, 3'b000, 3'b000, {4'd2, 4'd1, 4'd0}, '0);
      tick();
      chk("t1_gnt", 32'(obs_gnt), 32'(exp_seq[i]));
      if (i > 0) chk("t1_rvalid", 32'(obs_rv), 32'(exp_seq[i-1]));
    end

    // Requester 1 locks for a read then a write
    set(3'b111, 3'b010, 3'b000, {4'd0, 4'd3, 4'd0}, '0); tick();
    chk("t3_gnt_a", 32'(obs_gnt), 32'b010);
    set(3'b111, 3'b000, 3'b010, {4'd0, 4'd3, 4'd0}, {8'h00, 8'h5C, 8'h00}); tick();
    chk("t3_gnt_b", 32'(obs_gnt), 32'b010);
    chk("t3_busy", 32'(obs_busy), 32'd1);
    set(3'b111, 3'b000, 3'b000, '0, '0); tick();
    chk("t3_gnt_c", 32'(obs_gnt), 32'b100);

    // Write then read of the same address in consecutive cycles
    set(3'b001, 3'b000, 3'b001, {4'd0, 4'd0, 4'd5}, {8'h00, 8'h00, 8'h2A}); tick();
    chk("t2_we", 32'(obs_we), 32'd1);
    set(3'b010, 3'b000, 3'b000, {4'd0, 4'd5, 4'd0}, '0); tick();
    chk("t2_gnt", 32'(obs_gnt), 32'b010);
    set('0, '0, '0, '0, '0); tick();
    chk("t2_rvalid", 32'(obs_rv), 32'b010);
    chk("t2_rdata", 32'(obs_rd), 32'h2A);

    // Lock cap: owner 0 holds lock forever, requester 2 waits
    set(3'b100, 3'b000, 3'b000, '0, '0); tick();
    for (int i = 0; i < 4; i++) begin
      set(3'b101, 3'b001, 3'b000, {4'd9, 4'd0, 4'd7}, '0); tick();
      chk("t4_gnt_owner", 32'(obs_gnt), 32'b001);
    end
    set(3'b101, 3'b001, 3'b000, {4'd9, 4'd0, 4'd7}, '0); tick();
    chk("t4_gnt_release", 32'(obs_gnt), 32'b100);
    set('0, '0, '0, '0, '0); tick();

    // Owner drops its request while locked
    set(3'b100, 3'b100, 3'b000, {4'd4, 4'd0, 4'd0}, '0); tick();
    chk("t5_gnt_lock", 32'(obs_gnt), 32'b100);
    set(3'b001, 3'b000, 3'b000, {4'd0, 4'd0, 4'd1}, '0); tick();
    chk("t5_gnt_none", 32'(obs_gnt), 32'b000);
    tick();
    chk("t5_gnt_next", 32'(obs_gnt), 32'b001);
    chk("t5_busy", 32'(obs_busy), 32'd0);

    // Reset in the middle of a locked read
    set(3'b001, 3'b001, 3'b000, {4'd0, 4'd0, 4'd2}, '0); tick();
    rstn = 1'b0; tick();
    chk("t6_gnt", 32'(obs_gnt), 32'd0);
    chk("t6_we", 32'(obs_we), 32'd0);
    rstn = 1'b1;
    set(3'b111, 3'b000, 3'b000, '0, '0); tick();
    chk("t6_rvalid", 32'(obs_rv), 32'd0);
    chk("t6_gnt_after", 32'(obs_gnt), 32'b001);

    // Randomized traffic, lock-heavy, with occasional resets
    for (int n = 0; n < 800; n++) begin
      rstn = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) != 0) bus.req = NR'($urandom_range(0, 7));
      bus.lock  = ($urandom_range(0, 2) != 0) ? NR'($urandom_range(0, 7)) : '0;
      bus.we    = NR'($urandom_range(0, 7));
      bus.addr  = (NR*AW)'($urandom);
      bus.wdata = (NR*DW)'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
